// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the vertical-phase state type.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Vertical phase of the current line.
  typedef enum logic [1:0] {
    ACTIVE = 2'b00,
    FRONT  = 2'b01,
    SYNC   = 2'b10,
    BACK   = 2'b11
  } v_phase_e;

endpackage

// File: rtl/v_counter_sync_if.sv
// Vertical-timing bus: end-of-line pulse in, line count / sync / strobes out.
// Optional frame_cnt member present when VCNT_FRAME_CNT_EN is defined.
interface v_counter_sync_if;

  logic       trig_v;
  logic [9:0] v_count;
  logic       vsync;
  logic       v_active;
  logic       frame_start;
`ifdef VCNT_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  // Timing-chain side: drives trig_v, consumes the vertical outputs.
  modport master (
    output trig_v,
    input  v_count,
    input  vsync,
    input  v_active,
    input  frame_start
`ifdef VCNT_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

  // Vertical counter side.
  modport slave (
    input  trig_v,
    output v_count,
    output vsync,
    output v_active,
    output frame_start
`ifdef VCNT_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

endinterface

// File: rtl/v_counter_sync.sv
// Vertical line counter and vsync generator. Advances one line per sampled trig_v,
// sequences ACTIVE -> FRONT -> SYNC -> BACK and strobes frame_start on wrap.
// Optional 8-bit frame counter enabled by defining VCNT_FRAME_CNT_EN.
module v_counter_sync #(
  parameter int unsigned V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit          VSYNC_POL = 1'b0
) (
  input logic              clk,
  input logic              reset,
  v_counter_sync_if.slave  bus
);

  import vga_timing_pkg::*;

  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (V_TOTAL > 1024) begin : g_total_check
    $error("v_counter_sync: V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] LastLine  = 10'(V_TOTAL - 1);
  localparam logic [9:0] FrontLine = 10'(V_ACTIVE);
  localparam logic [9:0] SyncLine  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] BackLine  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  // Phase-boundary compares on the next line number.
  function automatic logic is_front_start(input logic [9:0] line);
    return line == FrontLine;
  endfunction

  function automatic logic is_sync_start(input logic [9:0] line);
    return line == SyncLine;
  endfunction

  function automatic logic is_back_start(input logic [9:0] line);
    return line == BackLine;
  endfunction

  logic [9:0] count_q, count_d;
  v_phase_e   state_q, state_d;
  logic       vsync_q, vsync_d;
  logic       v_active_q, v_active_d;
  logic       frame_start_q, frame_start_d;

  // Next line count, phase and output levels; outputs follow next-state values so
  // every registered output agrees with the registered count.
  always_comb begin
    count_d       = count_q;
    state_d       = state_q;
    frame_start_d = 1'b0;
    if (bus.trig_v) begin
      if (count_q == LastLine) begin
        count_d       = '0;
        frame_start_d = 1'b1;
      end else begin
        count_d = count_q + 10'd1;
      end
      case (state_q)
        ACTIVE: if (is_front_start(count_d)) state_d = FRONT;
        FRONT:  if (is_sync_start(count_d))  state_d = SYNC;
        SYNC:   if (is_back_start(count_d))  state_d = BACK;
        BACK:   if (count_d == '0)           state_d = ACTIVE;
        default: begin
          // Unknown encoding: restart the frame without a start strobe.
          state_d       = ACTIVE;
          count_d       = '0;
          frame_start_d = 1'b0;
        end
      endcase
    end
    vsync_d    = (state_d == SYNC) ? VSYNC_POL : ~VSYNC_POL;
    v_active_d = (state_d == ACTIVE);
  end

  // Counter, phase and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      state_q       <= ACTIVE;
      vsync_q       <= ~VSYNC_POL;
      v_active_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      v_active_q    <= v_active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.v_count     = count_q;
  assign bus.vsync       = vsync_q;
  assign bus.v_active    = v_active_q;
  assign bus.frame_start = frame_start_q;

`ifdef VCNT_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Steps together with frame_start so the new value appears with the strobe.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_v_counter_sync.sv
// Directed bench for v_counter_sync (default 640x480 vertical timing, active-low vsync).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_v_counter_sync;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  v_counter_sync_if vif ();

  v_counter_sync dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Hold trig_v at the given level for n sampling edges; returns on a falling edge.
  task automatic drive_cycles(input int n, input logic trig);
    for (int i = 0; i < n; i++) begin
      vif.trig_v = trig;
      @(negedge clk);
    end
    vif.trig_v = 1'b0;
  endtask

  task automatic apply_reset();
    vif.trig_v = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vif.trig_v = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vif.v_count !== 10'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", vif.v_count);
    end
    n_checks++;
    if (vif.v_active !== 1'b1 || vif.vsync !== 1'b1 || vif.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got act=%b vs=%b fs=%b expected act=1 vs=1 fs=0",
               vif.v_active, vif.vsync, vif.frame_start);
    end
    reset = 1'b0;
    @(negedge clk);
    // First pulse after reset counts.
    drive_cycles(1, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd1) begin
      n_fail++; $display("FAIL reset_first_pulse: got %0d expected 1", vif.v_count);
    end
    drive_cycles(299, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd300 || vif.v_active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_count: got cnt=%0d act=%b expected cnt=300 act=1",
               vif.v_count, vif.v_active);
    end
    // Asynchronous reset mid-frame, checked before any rising edge.
    reset = 1'b1;
    #1;
    n_checks++;
    if (vif.v_count !== 10'd0) begin
      n_fail++; $display("FAIL reset_async_count: got %0d expected 0", vif.v_count);
    end
    n_checks++;
    if (vif.v_active !== 1'b1 || vif.vsync !== 1'b1 || vif.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got act=%b vs=%b fs=%b expected act=1 vs=1 fs=0",
               vif.v_active, vif.vsync, vif.frame_start);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vif.frame_start !== 1'b0 || vif.v_count !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release: got fs=%b cnt=%0d expected fs=0 cnt=0",
               vif.frame_start, vif.v_count);
    end
  endtask

  task automatic test_full_frame();
    int exp_line;
    logic exp_act, exp_vs, exp_fs;
    apply_reset();
    for (int line = 1; line <= 525; line++) begin
      drive_cycles(1, 1'b1);
      exp_line = line % 525;
      exp_act  = (exp_line < 480);
      exp_vs   = !(exp_line >= 490 && exp_line <= 491);
      exp_fs   = (exp_line == 0);
      n_checks++;
      if (vif.v_count !== 10'(exp_line)) begin
        n_fail++; $display("FAIL frame_count: got %0d expected %0d", vif.v_count, exp_line);
      end
      n_checks++;
      if (vif.v_active !== exp_act) begin
        n_fail++;
        $display("FAIL frame_active line %0d: got %b expected %b", exp_line, vif.v_active, exp_act);
      end
      n_checks++;
      if (vif.vsync !== exp_vs) begin
        n_fail++;
        $display("FAIL frame_vsync line %0d: got %b expected %b", exp_line, vif.vsync, exp_vs);
      end
      n_checks++;
      if (vif.frame_start !== exp_fs) begin
        n_fail++;
        $display("FAIL frame_start line %0d: got %b expected %b", exp_line, vif.frame_start, exp_fs);
      end
      @(negedge clk);
      n_checks++;
      if (vif.frame_start !== 1'b0) begin
        n_fail++; $display("FAIL frame_start_width line %0d: got 1 expected 0", exp_line);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive_cycles(524, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd524 || vif.v_active !== 1'b0 || vif.vsync !== 1'b1 ||
        vif.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pre: got cnt=%0d act=%b vs=%b fs=%b expected cnt=524 act=0 vs=1 fs=0",
               vif.v_count, vif.v_active, vif.vsync, vif.frame_start);
    end
    drive_cycles(1, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd0 || vif.v_active !== 1'b1 || vif.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_post: got cnt=%0d act=%b fs=%b expected cnt=0 act=1 fs=1",
               vif.v_count, vif.v_active, vif.frame_start);
    end
    @(negedge clk);
    n_checks++;
    if (vif.frame_start !== 1'b0 || vif.v_count !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_strobe_width: got fs=%b cnt=%0d expected fs=0 cnt=0",
               vif.frame_start, vif.v_count);
    end
  endtask

  task automatic test_no_pulse();
    apply_reset();
    drive_cycles(490, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      n_checks++;
      if (vif.v_count !== 10'd490 || vif.vsync !== 1'b0 || vif.v_active !== 1'b0) begin
        n_fail++;
        $display("FAIL no_pulse cycle %0d: got cnt=%0d vs=%b act=%b expected cnt=490 vs=0 act=0",
                 i, vif.v_count, vif.vsync, vif.v_active);
      end
    end
  endtask

  task automatic test_multi_cycle();
    apply_reset();
    drive_cycles(488, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd488 || vif.vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_pre: got cnt=%0d vs=%b expected cnt=488 vs=1", vif.v_count, vif.vsync);
    end
    drive_cycles(3, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd491 || vif.vsync !== 1'b0 || vif.v_active !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_post: got cnt=%0d vs=%b act=%b expected cnt=491 vs=0 act=0",
               vif.v_count, vif.vsync, vif.v_active);
    end
    drive_cycles(1, 1'b1);
    n_checks++;
    if (vif.v_count !== 10'd492 || vif.vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_back: got cnt=%0d vs=%b expected cnt=492 vs=1", vif.v_count, vif.vsync);
    end
  endtask

`ifdef VCNT_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [7:0] exp_fc;
    apply_reset();
    exp_fc = 8'd0;
    n_checks++;
    if (vif.frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL fcnt_reset: got %0d expected 0", vif.frame_cnt);
    end
    for (int f = 1; f <= 256; f++) begin
      drive_cycles(524, 1'b1);
      n_checks++;
      if (vif.frame_cnt !== exp_fc) begin
        n_fail++; $display("FAIL fcnt_before frame %0d: got %0d expected %0d", f, vif.frame_cnt, exp_fc);
      end
      drive_cycles(1, 1'b1);
      exp_fc = exp_fc + 8'd1;
      n_checks++;
      if (vif.frame_cnt !== exp_fc || vif.frame_start !== 1'b1) begin
        n_fail++;
        $display("FAIL fcnt_step frame %0d: got cnt=%0d fs=%b expected cnt=%0d fs=1",
                 f, vif.frame_cnt, vif.frame_start, exp_fc);
      end
    end
    n_checks++;
    if (vif.frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL fcnt_wrap: got %0d expected 0", vif.frame_cnt);
    end
  endtask
`endif

  initial begin
    vif.trig_v = 1'b0;
    reset = 1'b1;
    test_reset();
    test_full_frame();
    test_wrap();
    test_no_pulse();
    test_multi_cycle();
`ifdef VCNT_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
